// File: rtl/load_use_hazard_unit_if.sv
// ID-stage hazard bus: the instruction under decode goes in, and stall/bubble control plus
// per-stage destination tracking come out.
interface load_use_hazard_unit_if;
  logic [31:0] id_ins;
  logic        id_valid;
  logic        flush;
  logic        stall;
  logic        bubble;
  logic [4:0]  ex_dest;
  logic [4:0]  mem_dest;
  logic [4:0]  wb_dest;
  logic        ex_load;
  logic        mem_load;
  logic [15:0] stall_cycles;

  modport master (
    output id_ins, id_valid, flush,
    input  stall, bubble, ex_dest, mem_dest, wb_dest, ex_load, mem_load, stall_cycles
  );

  modport slave (
    input  id_ins, id_valid, flush,
    output stall, bubble, ex_dest, mem_dest, wb_dest, ex_load, mem_load, stall_cycles
  );
endinterface

// File: rtl/load_use_hazard_unit.sv
// Load-use and branch-operand hazard detection: stalls ID when forwarding cannot supply
// an operand in time, and tracks EX/MEM/WB destinations plus a saturating stall counter.
module load_use_hazard_unit (
  input logic                   clk,
  input logic                   reset,
  load_use_hazard_unit_if.slave bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  id_dest;
  logic        id_load, id_branch, use_rs, use_rt;

  logic [4:0]  ex_dest_q, mem_dest_q, wb_dest_q;
  logic        ex_load_q, mem_load_q;
  logic [15:0] stall_cnt_q;

  logic        src_hit_ex, src_hit_mem;
  logic        stall_c;
  logic        issue;

  always_comb begin
    opcode    = bus.id_ins[31:26];
    rs        = bus.id_ins[25:21];
    rt        = bus.id_ins[20:16];
    rd        = bus.id_ins[15:11];
    id_dest   = '0;
    id_load   = 1'b0;
    id_branch = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        id_dest = rd;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
      end
      OP_LW: begin
        id_dest = rt;
        id_load = 1'b1;
        use_rs  = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        id_dest = rt;
        use_rs  = 1'b1;
      end
      OP_LUI: id_dest = rt;
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        id_branch = 1'b1;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      default: ;
    endcase
  end

  // A stage dest of 0 means "none", so a nonzero dest match also rules out source register 0.
  always_comb begin
    src_hit_ex  = (ex_dest_q != '0) &&
                  ((use_rs && (rs == ex_dest_q)) || (use_rt && (rt == ex_dest_q)));
    src_hit_mem = (mem_dest_q != '0) &&
                  ((use_rs && (rs == mem_dest_q)) || (use_rt && (rt == mem_dest_q)));
    stall_c     = bus.id_valid && !bus.flush &&
                  ((ex_load_q && src_hit_ex) ||
                   (id_branch && src_hit_ex) ||
                   (id_branch && mem_load_q && src_hit_mem));
    issue       = bus.id_valid && !stall_c && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_dest_q   <= '0;
      mem_dest_q  <= '0;
      wb_dest_q   <= '0;
      ex_load_q   <= 1'b0;
      mem_load_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_dest_q   <= issue ? id_dest : '0;
      ex_load_q   <= issue ? id_load : 1'b0;
      mem_dest_q  <= ex_dest_q;
      mem_load_q  <= ex_load_q;
      wb_dest_q   <= mem_dest_q;
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.bubble       = stall_c | bus.flush;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.mem_dest     = mem_dest_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.ex_load      = ex_load_q;
  assign bus.mem_load     = mem_load_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Self-checking bench for load_use_hazard_unit: directed hazard scenarios, randomized
// instruction streams against an in-flight instruction history model, and counter saturation.
module tb_load_use_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  load_use_hazard_unit_if bus ();

  load_use_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // History of issued instructions: index 0 = EX, 1 = MEM, 2 = WB.
  int   hist_dest [3];
  bit   hist_load [3];
  int   m_cnt;
  logic last_stall, last_bubble;

  function automatic logic [31:0] r_ins(int rs, int rt, int rd);
    logic [4:0] a, b, c;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
    return {6'h00, a, b, c, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    logic [4:0]  a, b;
    logic [15:0] c;
    a = rs[4:0]; b = rt[4:0]; c = imm[15:0];
    return {op, a, b, c};
  endfunction

  function automatic int m_dest(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return int'(ins[15:11]);
    if (op inside {6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) return int'(ins[20:16]);
    return 0;
  endfunction

  // Sources as a list of register numbers; register 0 and unread fields are left out.
  function automatic void m_srcs(input logic [31:0] ins, output int s [$]);
    logic [5:0] op;
    int rs, rt;
    op = ins[31:26];
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    s = {};
    if (op inside {6'h00, 6'h2B, 6'h04, 6'h05}) s = {rs, rt};
    else if (op inside {6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D}) s = {rs};
    s = s.find(x) with (x != 0);
  endfunction

  function automatic bit m_stall(logic [31:0] ins, bit valid, bit fl);
    int  s [$];
    int  hits_ex [$];
    int  hits_mem [$];
    bit  br;
    if (!valid || fl) return 1'b0;
    m_srcs(ins, s);
    br       = ins[31:26] inside {6'h04, 6'h05};
    hits_ex  = s.find(x) with (x == hist_dest[0]);
    hits_mem = s.find(x) with (x == hist_dest[1]);
    if (hist_load[0] && hits_ex.size() > 0) return 1'b1;
    if (br && hits_ex.size() > 0) return 1'b1;
    if (br && hist_load[1] && hits_mem.size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply ID inputs, check combinational outputs, clock, check registered outputs.
  task automatic cycle(input logic [31:0] ins, input bit valid, input bit fl, input bit rst,
                       input bit chk);
    bit e_stall;
    bus.id_ins   = ins;
    bus.id_valid = valid;
    bus.flush    = fl;
    reset        = rst;
    #1;
    e_stall     = m_stall(ins, valid, fl);
    last_stall  = bus.stall;
    last_bubble = bus.bubble;
    if (chk) begin
      check("stall", {31'd0, bus.stall}, {31'd0, e_stall});
      check("bubble", {31'd0, bus.bubble}, {31'd0, e_stall | fl});
    end
    @(posedge clk);
    if (rst) begin
      hist_dest = '{0, 0, 0};
      hist_load = '{0, 0, 0};
      m_cnt     = 0;
    end else begin
      hist_dest[2] = hist_dest[1];
      hist_dest[1] = hist_dest[0];
      hist_load[1] = hist_load[0];
      if (valid && !fl && !e_stall) begin
        hist_dest[0] = m_dest(ins);
        hist_load[0] = (ins[31:26] == 6'h23);
      end else begin
        hist_dest[0] = 0;
        hist_load[0] = 1'b0;
      end
      if (e_stall && m_cnt < 65535) m_cnt++;
    end
    #1;
    if (chk) begin
      check("ex_dest", {27'd0, bus.ex_dest}, hist_dest[0]);
      check("mem_dest", {27'd0, bus.mem_dest}, hist_dest[1]);
      check("wb_dest", {27'd0, bus.wb_dest}, hist_dest[2]);
      check("ex_load", {31'd0, bus.ex_load}, {31'd0, hist_load[0]});
      check("mem_load", {31'd0, bus.mem_load}, {31'd0, hist_load[1]});
      check("stall_cycles", {16'd0, bus.stall_cycles}, m_cnt);
    end
  endtask

  initial begin
    logic [31:0] lw8, add9_8, lw5, beq5, ins;
    logic [5:0]  ops [11];
    lw8    = i_ins(6'h23, 1, 8, 0);
    add9_8 = r_ins(8, 2, 9);
    lw5    = i_ins(6'h23, 0, 5, 4);
    beq5   = i_ins(6'h04, 5, 0, 3);
    ops    = '{6'h00, 6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h2B, 6'h04, 6'h05, 6'h02};
    hist_dest = '{0, 0, 0};
    hist_load = '{0, 0, 0};
    m_cnt  = 0;
    reset  = 1'b1;
    bus.id_ins   = '0;
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    @(posedge clk); #1;

    // Reset state, with flush high so bubble must follow flush alone.
    cycle(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_bubble", {31'd0, last_bubble}, 32'd1);
    check("rst_cnt", {16'd0, bus.stall_cycles}, 32'd0);

    // lw $8 then add $9,$8,$2: exactly one stall.
    cycle(lw8, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(add9_8, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lu_stall", {31'd0, last_stall}, 32'd1);
    check("lu_ex_dest", {27'd0, bus.ex_dest}, 32'd0);
    check("lu_mem_dest", {27'd0, bus.mem_dest}, 32'd8);
    check("lu_cnt", {16'd0, bus.stall_cycles}, 32'd1);
    cycle(add9_8, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lu_release", {31'd0, last_stall}, 32'd0);

    // ALU to ALU dependence: forwarding covers it, no stall.
    cycle(r_ins(1, 2, 8), 1'b1, 1'b0, 1'b0, 1'b1);
    check("alu_ex_dest", {27'd0, bus.ex_dest}, 32'd8);
    cycle(r_ins(8, 3, 9), 1'b1, 1'b0, 1'b0, 1'b1);
    check("alu_no_stall", {31'd0, last_stall}, 32'd0);
    check("alu_mem_dest", {27'd0, bus.mem_dest}, 32'd8);
    cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("alu_wb_dest", {27'd0, bus.wb_dest}, 32'd8);

    // Branch after lw: two stall cycles.
    cycle(32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(lw5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(beq5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("bl_stall1", {31'd0, last_stall}, 32'd1);
    cycle(beq5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("bl_stall2", {31'd0, last_stall}, 32'd1);
    cycle(beq5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("bl_release", {31'd0, last_stall}, 32'd0);
    check("bl_cnt", {16'd0, bus.stall_cycles}, 32'd2);

    // Register 0 never creates a hazard; sw reading a loaded reg as rt does.
    cycle(i_ins(6'h23, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(r_ins(0, 0, 2), 1'b1, 1'b0, 1'b0, 1'b1);
    check("r0_no_stall", {31'd0, last_stall}, 32'd0);
    cycle(i_ins(6'h23, 1, 4, 0), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(i_ins(6'h2B, 1, 4, 0), 1'b1, 1'b0, 1'b0, 1'b1);
    check("sw_stall", {31'd0, last_stall}, 32'd1);
    cycle(i_ins(6'h2B, 1, 4, 0), 1'b1, 1'b0, 1'b0, 1'b1);
    check("sw_release", {31'd0, last_stall}, 32'd0);

    // Flush beats a load-use condition.
    cycle(lw8, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(add9_8, 1'b1, 1'b1, 1'b0, 1'b1);
    check("fl_stall", {31'd0, last_stall}, 32'd0);
    check("fl_bubble", {31'd0, last_bubble}, 32'd1);
    check("fl_cnt", {16'd0, bus.stall_cycles}, 32'd3);

    // Reset in the middle of a branch-on-load stall.
    cycle(lw5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(beq5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(beq5, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mr_mem_dest", {27'd0, bus.mem_dest}, 32'd0);
    check("mr_cnt", {16'd0, bus.stall_cycles}, 32'd0);
    cycle(beq5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mr_no_stall", {31'd0, last_stall}, 32'd0);

    // Randomized streams over a small register window to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      int op_i;
      op_i = int'($urandom_range(0, 10));
      if (ops[op_i] == 6'h00)
        ins = r_ins(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
      else
        ins = i_ins(ops[op_i], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 65535)));
      cycle(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0, 1'b1);
    end

    // Saturation: lw / beq / beq gives two stalls per three cycles.
    cycle(32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 32770; i++) begin
      bit chk;
      chk = (i >= 32765);
      cycle(lw8, 1'b1, 1'b0, 1'b0, chk);
      cycle(i_ins(6'h05, 8, 0, 1), 1'b1, 1'b0, 1'b0, chk);
      cycle(i_ins(6'h05, 8, 0, 1), 1'b1, 1'b0, 1'b0, chk);
    end
    check("sat_cnt", {16'd0, bus.stall_cycles}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
